// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared definitions for the FIR tap sequencer slice: default sizing
//   constants and the sequencer state encoding.
package fir_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_TAPS      = 5;
  localparam int DEF_SEL_WIDTH = 3;
  localparam int DEF_ACC_WIDTH = 2 * DEF_WIDTH + 3;

  // IDLE  : waiting for a sample, delay line may shift
  // ISSUE : one tap operand pair per cycle to the multiplier
  // DRAIN : all taps issued, collecting remaining products
  // OUT   : result presented until downstream accepts it
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_t;

endpackage

// File: rtl/fir_accumulator.sv
// fir_accumulator
//   Two's-complement accumulator for the FIR sequencer. The incoming
//   product is sign-extended (or truncated) to the accumulator width and
//   the sum wraps modulo 2^ACC_WIDTH, no saturation.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the sum
//   clear    : synchronous clear at the start of a new sample
//   add_en   : add product into the sum this cycle
//   product  : signed multiplier result, PROD_WIDTH bits
//   acc      : signed running sum, ACC_WIDTH bits
module fir_accumulator
  import fir_pkg::*;
#(
  parameter int PROD_WIDTH = 2 * DEF_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         add_en,
  input  logic signed [PROD_WIDTH-1:0] product,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  // Work in whichever width is larger so that sign extension happens
  // before the slice; a narrower accumulator simply keeps the low bits,
  // which is exactly modulo-2^ACC_WIDTH arithmetic.
  localparam int EXT_WIDTH = (ACC_WIDTH > PROD_WIDTH) ? ACC_WIDTH : PROD_WIDTH;

  logic signed [EXT_WIDTH-1:0] product_ext;
  logic        [ACC_WIDTH-1:0] addend;
  logic        [ACC_WIDTH-1:0] sum;

  always_comb begin
    product_ext = EXT_WIDTH'(product);
    addend      = product_ext[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + addend;
    end
  end

  assign acc = sum;

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//   Control for a time-multiplexed FIR filter. On each accepted sample it
//   pulses shift_en to advance the external delay line, walks the tap index
//   over the coefficient/sample MUXes, and accumulates the products returned
//   by an external pipelined multiplier. Products are counted rather than
//   timed, so any multiplier latency works.
//
// Ports
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   in_valid      : a new sample is offered
//   in_ready      : block can accept a sample (IDLE only)
//   shift_en      : single-cycle delay line shift on sample accept
//   select        : tap index to the MUXes, holds outside ISSUE
//   mult_valid    : MUX outputs are a valid operand pair this cycle
//   product       : signed multiplier result
//   product_valid : product is valid this cycle
//   out_data      : filter output sample
//   out_valid     : out_data is valid
//   out_ready     : downstream accepts out_data
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TAPS      = DEF_TAPS,
  parameter int SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int ACC_WIDTH = 2 * WIDTH + 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        shift_en,
  output logic [SEL_WIDTH-1:0]        select,
  output logic                        mult_valid,
  input  logic signed [2*WIDTH-1:0]   product,
  input  logic                        product_valid,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready
);

  if (SEL_WIDTH < $clog2(TAPS)) begin : g_sel_width_check
    $error("fir_tap_sequencer: SEL_WIDTH too small for TAPS");
  end

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [SEL_WIDTH-1:0] LAST_TAP  = SEL_WIDTH'(TAPS - 1);
  localparam logic [CNT_W-1:0]     LAST_PROD = CNT_W'(TAPS - 1);

  fir_state_t           state;
  logic [SEL_WIDTH-1:0] tap_cnt;
  logic [CNT_W-1:0]     prod_cnt;

  logic accept;
  logic collect;
  logic last_product;

  always_comb begin
    accept       = (state == IDLE) && in_valid && !rst;
    collect      = ((state == ISSUE) || (state == DRAIN)) && product_valid;
    last_product = collect && (prod_cnt == LAST_PROD);
  end

  // Sequencer. tap_cnt stops at the last tap instead of wrapping, so the
  // select output naturally holds its final value after ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tap_cnt  <= '0;
      prod_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= ISSUE;
            tap_cnt  <= '0;
            prod_cnt <= '0;
          end
        end
        ISSUE: begin
          if (collect) begin
            prod_cnt <= prod_cnt + CNT_W'(1);
          end
          if (tap_cnt != LAST_TAP) begin
            tap_cnt <= tap_cnt + SEL_WIDTH'(1);
          end
          // With a zero-latency multiplier the last product lands on the
          // last issue cycle, so DRAIN is skipped entirely.
          if (last_product) begin
            state <= OUT;
          end else if (tap_cnt == LAST_TAP) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (collect) begin
            prod_cnt <= prod_cnt + CNT_W'(1);
          end
          if (last_product) begin
            state <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode the state register and are forced low while
  // reset is held, even though the state already reads IDLE then.
  always_comb begin
    in_ready   = (state == IDLE) && !rst;
    shift_en   = accept;
    mult_valid = (state == ISSUE) && !rst;
    out_valid  = (state == OUT) && !rst;
  end

  assign select = tap_cnt;

  fir_accumulator #(
    .PROD_WIDTH (2 * WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .add_en  (collect),
    .product (product),
    .acc     (out_data)
  );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;

  localparam int WIDTH     = 16;
  localparam int TAPS      = 5;
  localparam int SEL_WIDTH = 3;
  localparam int ACC_WIDTH = 2 * WIDTH + 3;
  localparam int ACC_W8    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic                        shift_en;
  logic [SEL_WIDTH-1:0]        select;
  logic                        mult_valid;
  logic signed [2*WIDTH-1:0]   product;
  logic                        product_valid;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  // Narrow-accumulator instance
  logic                        in_valid_w;
  logic                        in_ready_w;
  logic                        shift_en_w;
  logic [SEL_WIDTH-1:0]        select_w;
  logic                        mult_valid_w;
  logic signed [2*WIDTH-1:0]   product_w;
  logic                        product_valid_w;
  logic signed [ACC_W8-1:0]    out_data_w;
  logic                        out_valid_w;
  logic                        out_ready_w;

  int tests_run    = 0;
  int tests_failed = 0;

  int                 lat = 3;
  logic signed [15:0] sample = '0;

  fir_tap_sequencer #(
    .WIDTH     (WIDTH),
    .TAPS      (TAPS),
    .SEL_WIDTH (SEL_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .shift_en      (shift_en),
    .select        (select),
    .mult_valid    (mult_valid),
    .product       (product),
    .product_valid (product_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  fir_tap_sequencer #(
    .WIDTH     (WIDTH),
    .TAPS      (TAPS),
    .SEL_WIDTH (SEL_WIDTH),
    .ACC_WIDTH (ACC_W8)
  ) dut_w (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid_w),
    .in_ready      (in_ready_w),
    .shift_en      (shift_en_w),
    .select        (select_w),
    .mult_valid    (mult_valid_w),
    .product       (product_w),
    .product_valid (product_valid_w),
    .out_data      (out_data_w),
    .out_valid     (out_valid_w),
    .out_ready     (out_ready_w)
  );

  // Narrow instance: zero-latency multiplier that always returns 60
  assign product_w       = 32'sd60;
  assign product_valid_w = mult_valid_w;

  // Model delay line (x[0] newest) and coefficients {1,2,3,4,5}
  logic signed [15:0] x [8] = '{default: '0};
  logic signed [15:0] coef [8] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd0, 16'sd0, 16'sd0};

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) x[k] <= '0;
    end else if (shift_en) begin
      x[0] <= sample;
      for (int k = 1; k < 8; k++) x[k] <= x[k-1];
    end
  end

  // Model multiplier with run-time latency 0..15
  logic signed [31:0] xs, cs, mul_now;
  always_comb begin
    xs      = {{16{x[select][15]}}, x[select]};
    cs      = {{16{coef[select][15]}}, coef[select]};
    mul_now = mult_valid ? xs * cs : '0;
  end

  logic [15:0]        pv_pipe = '0;
  logic signed [31:0] pd_pipe [16] = '{default: '0};
  always @(posedge clk) begin
    pv_pipe    <= {pv_pipe[14:0], mult_valid};
    pd_pipe[0] <= mul_now;
    for (int k = 1; k < 16; k++) pd_pipe[k] <= pd_pipe[k-1];
  end

  always_comb begin
    if (lat == 0) begin
      product_valid = mult_valid;
      product       = mul_now;
    end else begin
      product_valid = pv_pipe[lat-1];
      product       = pd_pipe[lat-1];
    end
  end

  int                          lat_o;
  logic signed [ACC_WIDTH-1:0] data_o;
  logic [14:0]                 sel_o;

  // Offers one sample (called at a negedge), waits for out_valid with a
  // cycle budget, and optionally consumes the result. lat_o is cycles from
  // the accept cycle to first out_valid, -1 on timeout.
  task automatic send_sample(input logic signed [15:0] s, input bit consume,
                             output int lat_obs,
                             output logic signed [ACC_WIDTH-1:0] data_obs,
                             output logic [14:0] sel_trace);
    int n;
    int waited;
    int nsel;
    sel_trace = '0;
    nsel      = 0;
    sample    = s;
    in_valid  = 1'b1;
    waited    = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      if (mult_valid && nsel < 5) begin
        sel_trace[nsel*3 +: 3] = select;
        nsel++;
      end
      @(negedge clk);
      n++;
    end
    lat_obs  = out_valid ? n : -1;
    data_obs = out_data;
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_valid_w = 1'b0; out_ready_w = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    tests_run++;
    if (shift_en !== 1'b0) begin tests_failed++; $display("FAIL rst_shift_en: got %b expected 0", shift_en); end
    tests_run++;
    if (mult_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mult_valid: got %b expected 0", mult_valid); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (select !== 3'd0) begin tests_failed++; $display("FAIL rst_select: got %0d expected 0", select); end
    tests_run++;
    if (out_data !== '0) begin tests_failed++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
    tests_run++;
    if (in_ready_w !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready_w: got %b expected 0", in_ready_w); end
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_impulse();
    lat = 3;
    send_sample(16'sd1, 1'b1, lat_o, data_o, sel_o);
    tests_run++;
    if (data_o !== ACC_WIDTH'(1)) begin tests_failed++; $display("FAIL impulse_data: got %0d expected 1", data_o); end
    tests_run++;
    if (lat_o != 9) begin tests_failed++; $display("FAIL impulse_latency: got %0d expected 9", lat_o); end
    tests_run++;
    if (sel_o !== {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin
      tests_failed++; $display("FAIL impulse_select_seq: got %h expected %h", sel_o, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    end
  endtask

  task automatic test_constant();
    int exp_c [5] = '{102, 303, 604, 1005, 1500};
    for (int i = 0; i < 5; i++) begin
      send_sample(16'sd100, 1'b1, lat_o, data_o, sel_o);
      tests_run++;
      if (data_o !== ACC_WIDTH'(exp_c[i])) begin
        tests_failed++; $display("FAIL const_out[%0d]: got %0d expected %0d", i, data_o, exp_c[i]);
      end
    end
  endtask

  task automatic test_latency_sweep();
    int lats [2] = '{0, 8};
    int exp_l [2] = '{6, 14};
    for (int j = 0; j < 2; j++) begin
      lat = lats[j];
      repeat (20) @(negedge clk);
      for (int i = 0; i < 5; i++) send_sample(16'sd0, 1'b1, lat_o, data_o, sel_o);
      tests_run++;
      if (data_o !== '0) begin tests_failed++; $display("FAIL sweep_flush[L=%0d]: got %0d expected 0", lat, data_o); end
      send_sample(16'sd1, 1'b1, lat_o, data_o, sel_o);
      tests_run++;
      if (data_o !== ACC_WIDTH'(1)) begin tests_failed++; $display("FAIL sweep_data[L=%0d]: got %0d expected 1", lat, data_o); end
      tests_run++;
      if (lat_o != exp_l[j]) begin tests_failed++; $display("FAIL sweep_latency[L=%0d]: got %0d expected %0d", lat, lat_o, exp_l[j]); end
    end
    send_sample(16'sd100, 1'b1, lat_o, data_o, sel_o);
    tests_run++;
    if (data_o !== ACC_WIDTH'(102)) begin tests_failed++; $display("FAIL sweep_second[L=8]: got %0d expected 102", data_o); end
  endtask

  task automatic test_stall();
    lat = 3;
    repeat (20) @(negedge clk);
    send_sample(16'sd5, 1'b0, lat_o, data_o, sel_o);
    tests_run++;
    if (data_o !== ACC_WIDTH'(208)) begin tests_failed++; $display("FAIL stall_first_data: got %0d expected 208", data_o); end
    sample   = 16'sd77;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== ACC_WIDTH'(208)) begin
        tests_failed++; $display("FAIL stall_hold[%0d]: got valid=%b data=%0d expected valid=1 data=208", i, out_valid, out_data);
      end
      tests_run++;
      if (in_ready !== 1'b0 || shift_en !== 1'b0) begin
        tests_failed++; $display("FAIL stall_block[%0d]: got in_ready=%b shift_en=%b expected 0 0", i, in_ready, shift_en);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stall_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    tests_run++;
    if (x[0] !== 16'sd5 || x[1] !== 16'sd100) begin
      tests_failed++; $display("FAIL stall_delay_line: got x0=%0d x1=%0d expected 5 100", x[0], x[1]);
    end
  endtask

  task automatic test_wrap();
    int n;
    tests_run++;
    if (in_ready_w !== 1'b1) begin tests_failed++; $display("FAIL wrap_ready: got %b expected 1", in_ready_w); end
    in_valid_w = 1'b1;
    @(negedge clk);
    in_valid_w = 1'b0;
    n = 1;
    while (!out_valid_w && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!out_valid_w || n != 6) begin tests_failed++; $display("FAIL wrap_latency: got %0d expected 6", out_valid_w ? n : -1); end
    tests_run++;
    if (out_data_w !== 8'sd44) begin tests_failed++; $display("FAIL wrap_data: got %0d expected 44", out_data_w); end
    out_ready_w = 1'b1;
    @(negedge clk);
    out_ready_w = 1'b0;
  endtask

  task automatic test_reset_abort();
    int n;
    lat      = 3;
    sample   = 16'sd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(mult_valid && select == 3'd2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!(mult_valid && select == 3'd2)) begin tests_failed++; $display("FAIL abort_reach_tap2: got select=%0d expected 2", select); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (select !== 3'd0 || out_data !== '0) begin
      tests_failed++; $display("FAIL abort_cleared: got select=%0d data=%0d expected 0 0", select, out_data);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_idle: got %b expected 1", in_ready); end
    repeat (6) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_no_output: got %b expected 0", out_valid); end
    send_sample(16'sd7, 1'b1, lat_o, data_o, sel_o);
    tests_run++;
    if (data_o !== ACC_WIDTH'(7)) begin tests_failed++; $display("FAIL abort_next_data: got %0d expected 7", data_o); end
    tests_run++;
    if (lat_o != 9) begin tests_failed++; $display("FAIL abort_next_latency: got %0d expected 9", lat_o); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_constant();
    test_latency_sweep();
    test_stall();
    test_wrap();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample and coefficient width in bits.
REQ-002 SHALL have parameter TAPS, default 5, number of filter taps, which is also the number of MUX inputs.
REQ-003 SHALL have parameter SEL_WIDTH, default 3, MUX select width; it is at least $clog2(TAPS).
REQ-004 SHALL have parameter ACC_WIDTH, default 2*WIDTH+3, accumulator width.
REQ-005 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit; a new sample is offered.
REQ-008 SHALL have port in_ready, output, 1 bit; the block can accept a sample.
REQ-009 SHALL have port shift_en, output, 1 bit; one-cycle pulse that shifts the sample delay line.
REQ-010 SHALL have port select, output, SEL_WIDTH bits; tap index driven to the coefficient/sample MUXes.
REQ-011 SHALL have port mult_valid, output, 1 bit; the MUX outputs this cycle are a valid multiplier operand pair.
REQ-012 SHALL have port product, input, 2*WIDTH bits, signed; pipelined multiplier result.
REQ-013 SHALL have port product_valid, input, 1 bit; product is valid this cycle.
REQ-014 SHALL have port out_data, output, ACC_WIDTH bits, signed; filter output sample.
REQ-015 SHALL have port out_valid, output, 1 bit; out_data is valid.
REQ-016 SHALL have port out_ready, input, 1 bit; the downstream block accepts out_data.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DRAIN, OUT.
REQ-018 In IDLE: in_ready=1. When in_valid=1, shift_en=1 combinationally in the same cycle, and the next state is ISSUE with tap counter=0 and accumulator and product count cleared.
REQ-019 In ISSUE: select=tap counter and mult_valid=1; the counter increments each cycle. At counter==TAPS-1 the next state is DRAIN.
REQ-020 Outside ISSUE: mult_valid=0, select holds its last value, in_ready=0 except in IDLE, and shift_en=0 except on an IDLE accept.
REQ-021 In ISSUE and DRAIN, each cycle with product_valid=1 SHALL add sign-extended product into the accumulator and increment the product count.
REQ-022 When the product count reaches TAPS, the next state is OUT. The block counts products and does not assume any multiplier latency, so multiplier latency 0..15 SHALL all work.
REQ-023 product_valid in IDLE or OUT SHALL be ignored.
REQ-024 Accumulation SHALL be two's-complement and wrap modulo 2^ACC_WIDTH, with no saturation.
REQ-025 In OUT: out_valid=1 and out_data=accumulator, held stable until out_ready=1. The transition to IDLE happens on that cycle.
REQ-026 Latency: a sample accepted in cycle t with multiplier latency L gives out_valid first high in cycle t+TAPS+L+1.
REQ-027 A sample offered while the block is busy SHALL stall (in_ready=0). Samples are never dropped or double-shifted.
REQ-028 A product arriving in the same cycle as the last issue (L=0) SHALL still be accumulated.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, tap counter=0, product count=0, accumulator=0, select=0, out_data=0.
REQ-030 While rst is asserted the outputs SHALL be: out_valid=0, mult_valid=0, shift_en=0, in_ready=0.
REQ-031 Reset asserted mid-ISSUE or mid-DRAIN SHALL abort the computation. The next sample after reset SHALL produce a clean result with no residue from the aborted one.

Structure
REQ-032 Package fir_pkg SHALL hold the FSM state enum typedef and the default TAPS, WIDTH and ACC_WIDTH constants.
REQ-033 The accumulator (clear, add-enable, wrap) SHALL be a sub-module named fir_accumulator. The FSM and counters stay in the top level.

Verification
REQ-034 The bench SHALL cover these scenarios with TAPS=5, WIDTH=16, and a model multiplier of latency L=3 with coefficients {1,2,3,4,5}:
- Sample 1 after zero history: products {1,0,0,0,0}; require out_data=1, with out_valid at accept cycle +9.
- Constant input 100 for five samples: the fifth output is 1500.
- Latency sweep L=0 and L=8: outputs match the L=3 run, with out_valid at accept cycle +6 and +14 respectively.
- out_ready held low for 10 cycles: out_data is stable, in_ready=0, and a second in_valid is not accepted and shift_en stays 0.
- Wrap: ACC_WIDTH=8, products five times 60 (sum 300): out_data=44.
- rst pulse during ISSUE at tap 2, then sample 7: output is 7 with no contribution from the aborted sample.
